// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 4x16 register-file memory (mem8x16) between port A
// (CPU load/store) and port B (debug/loader) with round-robin arbitration.
// Latency: in-range access acks 2 cycles after the request is sampled, out-of-range acks after 1.
// Backpressure: requesters hold X_req until X_ack; a losing request stays pending and is served next.
//
// Ports:
//   clkp, rstp                     clock (also the memory clock), async active-high reset
//   a_req/a_we/a_addr/a_wdata      port A request, held stable until a_ack
//   a_ack/a_err/a_rdata            port A one-cycle completion, range error, read data
//   b_*                            port B, same as port A
//   mem_cs/mem_we/mem_addr/mem_din memory controls, launched on the falling clkp edge
//   mem_dout                       memory read data, latched in the memory while cs & ~we
//   busy                           high whenever the sequencer is not idle
module mem_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic          clkp,
    input  logic          rstp,
    // port A
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    // port B
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    // memory side
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Port identifiers used for the grant and round-robin history.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One extra bit so the range compare works for any DEPTH up to 2**AW.
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_last;      // port granted most recently
    logic          r_gnt;       // port owning the current access
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;

    // Negedge-launched memory controls
    logic          r_mem_cs;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;

    // Arbitration result for the current IDLE cycle
    logic          w_grant;
    logic          w_win_b;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_oor;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last time wins, so continuous contention alternates A, B.
    // ------------------------------------------------------------------
    always_comb begin
        w_win_b     = b_req && (!a_req || (r_last == PORT_A));
        w_sel_we    = w_win_b ? b_we    : a_we;
        w_sel_addr  = w_win_b ? b_addr  : a_addr;
        w_sel_wdata = w_win_b ? b_wdata : a_wdata;
        w_oor       = ({1'b0, w_sel_addr} >= LP_DEPTH);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_grant = 1'b1;
                    // Out-of-range requests skip the memory cycle entirely.
                    w_state_nxt = w_oor ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register, request capture and read-data return
    // ------------------------------------------------------------------
    always_ff @(posedge clkp or posedge rstp) begin
        if (rstp) begin
            r_state   <= ST_IDLE;
            r_last    <= PORT_B;   // so A wins the first tie
            r_gnt     <= PORT_A;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant) begin
                r_last  <= w_win_b;
                r_gnt   <= w_win_b;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_err   <= w_oor;
                // A rejected access returns zero data alongside the error.
                if (w_oor) begin
                    if (w_win_b) begin
                        r_b_rdata <= '0;
                    end else begin
                        r_a_rdata <= '0;
                    end
                end
            end

            // The posedge ending ACCESS is the read-capture edge; mem_dout
            // has been stable since the preceding falling edge.
            if ((r_state == ST_ACCESS) && !r_we) begin
                if (r_gnt == PORT_B) begin
                    r_b_rdata <= mem_dout;
                end else begin
                    r_a_rdata <= mem_dout;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory controls are launched on the falling edge so that cs/we only
    // move while clkp is low; the memory's clk & we & cs term therefore
    // cannot glitch. cs covers exactly the negedge-to-negedge window that
    // contains the posedge ending ACCESS.
    // ------------------------------------------------------------------
    always_ff @(negedge clkp or posedge rstp) begin
        if (rstp) begin
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_cs   <= (r_state == ST_ACCESS);
            r_mem_we   <= (r_state == ST_ACCESS) && r_we;
            r_mem_addr <= r_addr;
            r_mem_din  <= r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_ack    = (r_state == ST_RESP) && (r_gnt == PORT_A);
    assign b_ack    = (r_state == ST_RESP) && (r_gnt == PORT_B);
    assign a_err    = a_ack && r_err;
    assign b_err    = b_ack && r_err;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

    assign mem_cs   = r_mem_cs;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

    assign busy     = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // Acks are exclusive between the ports.
    assert property (@(posedge clkp) disable iff (rstp) !(a_ack && b_ack));

    // A rejected request never reaches the memory cycle.
    assert property (@(posedge clkp) disable iff (rstp)
                     (r_state == ST_ACCESS) |-> !r_err);

    // RESP lasts exactly one cycle, so an ack is never stretched.
    assert property (@(posedge clkp) disable iff (rstp)
                     (r_state == ST_RESP) |=> (r_state == ST_IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural mem8x16 model.
// Expected acks are queued when a request is driven and popped when an ack appears.
// Requesters follow the hold-until-ack protocol; the bench never stalls the DUT.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clkp = 1'b0;
    logic          rstp = 1'b1;

    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack, a_err;
    logic [DW-1:0] a_rdata;

    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack, b_err;
    logic [DW-1:0] b_rdata;

    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          busy;

    mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(4)) dut (
        .clkp(clkp), .rstp(rstp),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clkp = ~clkp;

    // Behavioural mem8x16: write on posedge while cs & we, read data latched while cs & ~we.
    logic [DW-1:0] mem [0:3];
    always @(posedge clkp) begin
        if (mem_cs === 1'b1 && mem_we === 1'b1) mem[mem_addr[1:0]] <= mem_din;
    end
    always @(mem_cs or mem_we or mem_addr) begin
        if (mem_cs === 1'b1 && mem_we === 1'b0) mem_dout = mem[mem_addr[1:0]];
    end

    // Activity monitors for the memory interface.
    int  cs_rises = 0, cs_hi = 0, glitch_bad = 0, ctl_changes = 0;
    time t_neg = 0;
    always @(posedge mem_cs) cs_rises <= cs_rises + 1;
    always @(posedge clkp) if (mem_cs === 1'b1) cs_hi <= cs_hi + 1;
    always @(negedge clkp) t_neg <= $time;
    always @(mem_cs or mem_we or mem_addr or mem_din) begin
        if (rstp === 1'b0) begin
            ctl_changes <= ctl_changes + 1;
            if ($time != t_neg || clkp !== 1'b0) glitch_bad <= glitch_bad + 1;
        end
    end

    typedef struct {
        logic          port_b;
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rdata;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;

    function automatic exp_t mk_exp(logic pb, logic er, logic crd, logic [DW-1:0] rd, int lat);
        exp_t e;
        e.port_b = pb; e.err = er; e.chk_rd = crd; e.rdata = rd; e.lat = lat;
        return e;
    endfunction

    task automatic tick();
        @(posedge clkp);
        #1;
    endtask

    // Waits (bounded) for the next ack on either port and reports what it saw.
    task automatic wait_ack(input int budget, output logic got, output logic pb, output logic er,
                            output logic [DW-1:0] rd, output int cyc, output logic both);
        got = 1'b0; pb = 1'b0; er = 1'b0; rd = '0; cyc = 0; both = 1'b0;
        while (!got && cyc < budget) begin
            tick();
            cyc++;
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                got  = 1'b1;
                both = a_ack && b_ack;
                pb   = b_ack;
                er   = b_ack ? b_err : a_err;
                rd   = b_ack ? b_rdata : a_rdata;
            end
        end
    endtask

    task automatic test_reset();
        logic [2*DW+2*AW+DW+6:0] outs;
        rstp = 1'b1;
        repeat (2) @(posedge clkp);
        #1;
        outs = {a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, mem_cs, mem_we, mem_addr, mem_din, busy};
        n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rstp = 1'b0;
        // Abort a write in the middle of its ACCESS cycle.
        mem[3] = 16'hAAAA;
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 16'h5555;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_access: got %b expected 1", busy); end
        @(negedge clkp); #1;
        n_checks++; if ({mem_cs, mem_we} !== 2'b11) begin n_fail++; $display("FAIL reset_cs_before_abort: got %b expected 11", {mem_cs, mem_we}); end
        rstp = 1'b1;
        #1;
        outs = {a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, mem_cs, mem_we, mem_addr, mem_din, busy};
        n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL reset_mid_access_outputs: got %h expected 0", outs); end
        a_req = 1'b0; a_we = 1'b0;
        tick(); tick();
        rstp = 1'b0;
        tick();
        n_checks++; if (mem[3] !== 16'hAAAA) begin n_fail++; $display("FAIL reset_row_unchanged: got %h expected aaaa", mem[3]); end
        n_checks++; if ({a_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_no_ack: got %b expected 00", {a_ack, busy}); end
    endtask

    task automatic test_single_rw();
        logic got, pb, er, both;
        logic [DW-1:0] rd;
        int cyc, r0, h0;
        exp_t e;
        r0 = cs_rises; h0 = cs_hi;
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_wdata = 16'hBEEF;
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, '0, 2));
        wait_ack(10, got, pb, er, rd, cyc, both);
        a_req = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({got, pb, er} !== {1'b1, e.port_b, e.err}) begin n_fail++; $display("FAIL wr_ack: got/port/err %b expected %b", {got, pb, er}, {1'b1, e.port_b, e.err}); end
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL wr_latency: got %0d expected %0d", cyc, e.lat); end
        tick();
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_one_cycle: got %b expected 0", a_ack); end
        n_checks++; if (mem[2] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_row: got %h expected beef", mem[2]); end
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2; a_wdata = 16'h0000;
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b1, 16'hBEEF, 2));
        wait_ack(10, got, pb, er, rd, cyc, both);
        a_req = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({got, pb, er} !== {1'b1, e.port_b, e.err}) begin n_fail++; $display("FAIL rd_ack: got/port/err %b expected %b", {got, pb, er}, {1'b1, e.port_b, e.err}); end
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rd, e.rdata); end
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", cyc, e.lat); end
        tick();
        n_checks++; if ({cs_rises - r0, cs_hi - h0} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL rw_cs_periods: got rises %0d high %0d expected 2 2", cs_rises - r0, cs_hi - h0); end
    endtask

    task automatic test_contention();
        logic got, pb, er, both;
        logic [DW-1:0] rd;
        int cyc;
        exp_t e;
        rstp = 1'b1;
        mem[1] = 16'h1234;
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd1;
        tick();
        rstp = 1'b0;
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b1, 16'h1234, 2));
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 16'h1234, 3));
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b1, 16'h1234, 3));
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 16'h1234, 3));
        for (int k = 0; k < 4; k++) begin
            wait_ack(12, got, pb, er, rd, cyc, both);
            if (k == 3) begin a_req = 1'b0; b_req = 1'b0; end
            e = sb.pop_front();
            n_checks++; if ({got, both, pb, er} !== {1'b1, 1'b0, e.port_b, e.err}) begin n_fail++; $display("FAIL cont_ack%0d: got/both/port/err %b expected %b", k, {got, both, pb, er}, {1'b1, 1'b0, e.port_b, e.err}); end
            n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL cont_data%0d: got %h expected %h", k, rd, e.rdata); end
            n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL cont_spacing%0d: got %0d expected %0d", k, cyc, e.lat); end
        end
        tick(); tick(); tick();
        n_checks++; if ({busy, a_ack, b_ack} !== 3'b000) begin n_fail++; $display("FAIL cont_idle_after: got %b expected 000", {busy, a_ack, b_ack}); end
    endtask

    task automatic test_out_of_range();
        logic got, pb, er, both;
        logic [DW-1:0] rd;
        int cyc, r0;
        exp_t e;
        r0 = cs_rises;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd5;
        sb.push_back(mk_exp(1'b1, 1'b1, 1'b1, 16'h0000, 1));
        wait_ack(10, got, pb, er, rd, cyc, both);
        b_req = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({got, pb, er} !== {1'b1, e.port_b, e.err}) begin n_fail++; $display("FAIL oor_rd_ack: got/port/err %b expected %b", {got, pb, er}, {1'b1, e.port_b, e.err}); end
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL oor_rd_data: got %h expected %h", rd, e.rdata); end
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL oor_rd_latency: got %0d expected %0d", cyc, e.lat); end
        tick();
        mem[3] = 16'h3333;
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 16'hCAFE;
        sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, '0, 1));
        wait_ack(10, got, pb, er, rd, cyc, both);
        a_req = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({got, pb, er} !== {1'b1, e.port_b, e.err}) begin n_fail++; $display("FAIL oor_wr_ack: got/port/err %b expected %b", {got, pb, er}, {1'b1, e.port_b, e.err}); end
        tick(); tick();
        n_checks++; if (cs_rises - r0 !== 0) begin n_fail++; $display("FAIL oor_no_cs: got %0d rises expected 0", cs_rises - r0); end
        n_checks++; if (mem[3] !== 16'h3333) begin n_fail++; $display("FAIL oor_row_alias: got %h expected 3333", mem[3]); end
    endtask

    task automatic test_interleave();
        logic got, pb, er, both;
        logic [DW-1:0] rd;
        int cyc;
        exp_t e;
        rstp = 1'b1;
        mem[0] = 16'hDEAD;
        tick();
        rstp = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 16'h00FF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd0;
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, '0, 2));
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 16'h00FF, 3));
        for (int k = 0; k < 2; k++) begin
            wait_ack(12, got, pb, er, rd, cyc, both);
            if (a_ack === 1'b1) a_req = 1'b0;
            if (b_ack === 1'b1) b_req = 1'b0;
            e = sb.pop_front();
            n_checks++; if ({got, pb, er} !== {1'b1, e.port_b, e.err}) begin n_fail++; $display("FAIL ilv_ack%0d: got/port/err %b expected %b", k, {got, pb, er}, {1'b1, e.port_b, e.err}); end
            n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL ilv_spacing%0d: got %0d expected %0d", k, cyc, e.lat); end
            if (e.chk_rd) begin
                n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL ilv_data%0d: got %h expected %h", k, rd, e.rdata); end
            end
        end
        tick(); tick();
    endtask

    task automatic test_glitch();
        n_checks++; if (glitch_bad !== 0) begin n_fail++; $display("FAIL glitch_free_controls: got %0d off-negedge changes expected 0", glitch_bad); end
        n_checks++; if (ctl_changes < 8) begin n_fail++; $display("FAIL glitch_activity: got %0d control changes expected at least 8", ctl_changes); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        test_reset();
        test_single_rw();
        test_contention();
        test_out_of_range();
        test_interleave();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within 50000 time units");
        $fatal(1);
    end

endmodule
